uart_rdata_sender: RTL and testbench

Transmit-side formatter for monitor memory dumps. Accepts the 64-bit read-data word and its start pulse from the monitor logic, renders it as ASCII hex with a line terminator, pushes characters into the UART transmit queue, then returns `flushing_wq` once the queue has drained. This pulse lets the dump sequencer fetch the next word. It sits between the monitor logic and the UART TX FIFO/serializer.

---
 rtl/uart_rdata_sender.sv | 137 +++++++++++++
 tb/tb_uart_rdata_sender.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rdata_sender.sv
// uart_rdata_sender
//   Renders a 64-bit monitor read-data word as ASCII hex, "HHHHHHHH HHHHHHHH"
//   followed by a line terminator, pushes it into the UART TX FIFO, waits for
//   the transmitter to drain, then pulses flushing_wq so the dump sequencer
//   can fetch the next word.
//
//   Build option: define UART_RDATA_SND_CRLF_EN for a CR LF terminator
//   (19 characters per word); otherwise LF only (18 characters per word).
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   rdata_snd_start  one-cycle start pulse, rdata_snd valid this cycle
//   rdata_snd        {data_0, data_1}; data_0 printed first
//   snd_abort        abandon the current word (no flushing_wq)
//   tx_full          TX FIFO cannot accept a character this cycle
//   tx_empty         TX FIFO and serializer idle
//   tx_push          FIFO write strobe (combinational from state + tx_full)
//   tx_char          character to the FIFO, valid with tx_push
//   flushing_wq      one-cycle pulse after a word has fully drained
//   snd_busy         high whenever the sender is not idle
module uart_rdata_sender #(
  parameter int unsigned CHAR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdata_snd_start,
  input  logic [63:0]       rdata_snd,
  input  logic              snd_abort,
  input  logic              tx_full,
  input  logic              tx_empty,
  output logic              tx_push,
  output logic [CHAR_W-1:0] tx_char,
  output logic              flushing_wq,
  output logic              snd_busy
);

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned DATA_W  = 64;
  localparam logic [IDX_W-1:0] SPACE_IDX = 5'd8;
`ifdef UART_RDATA_SND_CRLF_EN
  localparam logic [IDX_W-1:0] LAST_IDX  = 5'd18;
`else
  localparam logic [IDX_W-1:0] LAST_IDX  = 5'd17;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [DATA_W-1:0]  data_q,  data_d;

  logic [3:0]         nib_sel;
  logic [3:0]         nibble;
  logic [7:0]         char8;

  // State, index and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; abort overrides everything, including a start in IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (rdata_snd_start) begin
          data_d  = rdata_snd;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_full) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      DRAIN: begin
        if (tx_empty) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (snd_abort) begin
      state_d = IDLE;
      idx_d   = '0;
      data_d  = data_q;
    end
  end

  // Character decode: index 9..16 skips the space, so nibble number is idx-1
  always_comb begin
    nib_sel = (idx_q < SPACE_IDX) ? idx_q[3:0] : 4'(idx_q - 5'd1);
    // nibble n sits at bit offset 60-4n = 4*(15-n)
    nibble  = data_q[{~nib_sel, 2'b00} +: 4];
    char8   = (nibble < 4'd10) ? (8'h30 + 8'(nibble)) : (8'h37 + 8'(nibble));
    if (idx_q == SPACE_IDX) char8 = 8'h20;
`ifdef UART_RDATA_SND_CRLF_EN
    if (idx_q == LAST_IDX - 5'd1) char8 = 8'h0D;
`endif
    if (idx_q == LAST_IDX) char8 = 8'h0A;
  end

  // FIFO interface is combinational so a push lands in the cycle it is offered
  always_comb begin
    tx_push     = (state_q == SEND) && !tx_full;
    tx_char     = (state_q == SEND) ? CHAR_W'(char8) : '0;
    flushing_wq = (state_q == DONE);
    snd_busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_rdata_sender.sv
// Directed bench for uart_rdata_sender: stream content, push timing,
// backpressure, drain wait, abort, ignored start and reset behaviour.
module tb_uart_rdata_sender;

  localparam int unsigned CHAR_W = 8;
`ifdef UART_RDATA_SND_CRLF_EN
  localparam int    NT   = 19;
  localparam string TERM = "\r\n";
`else
  localparam int    NT   = 18;
  localparam string TERM = "\n";
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rdata_snd_start;
  logic [63:0]       rdata_snd;
  logic              snd_abort;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic [CHAR_W-1:0] tx_char;
  logic              flushing_wq;
  logic              snd_busy;

  int n_tests = 0;
  int n_fail  = 0;

  int  cyc = 0;
  byte got_q[$];
  int  push_cyc_q[$];
  int  flush_cyc_q[$];
  int  full_push_viol;
  int  busy_low_cnt;

  uart_rdata_sender #(.CHAR_W(CHAR_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdata_snd_start (rdata_snd_start),
    .rdata_snd       (rdata_snd),
    .snd_abort       (snd_abort),
    .tx_full         (tx_full),
    .tx_empty        (tx_empty),
    .tx_push         (tx_push),
    .tx_char         (tx_char),
    .flushing_wq     (flushing_wq),
    .snd_busy        (snd_busy)
  );

  always #5 clk = ~clk;

  task automatic clear_log();
    got_q.delete();
    push_cyc_q.delete();
    flush_cyc_q.delete();
    full_push_viol = 0;
    busy_low_cnt   = 0;
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, log what the DUT did
  task automatic run_cycle(input logic full, input logic empty, input logic start,
                           input logic abort, input logic [63:0] w);
    @(negedge clk);
    tx_full = full; tx_empty = empty; rdata_snd_start = start;
    snd_abort = abort; rdata_snd = w;
    #1;
    if (tx_push === 1'b1) begin
      got_q.push_back(byte'(tx_char[7:0]));
      push_cyc_q.push_back(cyc);
      if (tx_full) full_push_viol++;
    end
    if (flushing_wq === 1'b1) flush_cyc_q.push_back(cyc);
    if (snd_busy !== 1'b1) busy_low_cnt++;
    cyc++;
  endtask

  function automatic string got_str();
    string s = "";
    foreach (got_q[i]) s = {s, $sformatf("%c", got_q[i])};
    return s;
  endfunction

  function automatic int first_diff(input string a, input string b);
    int n = (a.len() < b.len()) ? a.len() : b.len();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    return n;
  endfunction

  function automatic int first_push();
    return (push_cyc_q.size() > 0) ? push_cyc_q[0] : -1;
  endfunction

  function automatic int last_push();
    return (push_cyc_q.size() > 0) ? push_cyc_q[push_cyc_q.size()-1] : -1;
  endfunction

  function automatic int flush_at();
    return (flush_cyc_q.size() == 1) ? flush_cyc_q[0] : -1;
  endfunction

  task automatic test_reset();
    string s;
    rst_n = 1'b0;
    tx_full = 1'b0; tx_empty = 1'b1; rdata_snd_start = 1'b0;
    snd_abort = 1'b0; rdata_snd = '0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({tx_push, tx_char, flushing_wq, snd_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got push=%b char=%h flush=%b busy=%b, want all 0",
               tx_push, tx_char, flushing_wq, snd_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Reset asserted mid-word clears outputs immediately
    clear_log();
    run_cycle(0, 1, 1, 0, 64'h0123_4567_89AB_CDEF);
    repeat (4) run_cycle(0, 1, 0, 0, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tx_push, tx_char, flushing_wq, snd_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_midword: got push=%b char=%h flush=%b busy=%b, want all 0",
               tx_push, tx_char, flushing_wq, snd_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (NT + 5) run_cycle(0, 1, 0, 0, 64'h0);
    s = got_str();
    n_tests++;
    if (got_q.size() != 0 || flush_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_resume: got %0d pushes %0d flushes, want 0 and 0",
               got_q.size(), flush_cyc_q.size());
    end
  endtask

  task automatic test_basic();
    string exp_s = {"01234567 89ABCDEF", TERM};
    string s;
    int n0;
    clear_log();
    run_cycle(0, 1, 1, 0, 64'h0123_4567_89AB_CDEF);
    n0 = cyc - 1;
    repeat (NT + 6) run_cycle(0, 1, 0, 0, 64'h0);
    s = got_str();
    n_tests++;
    if (s != exp_s) begin
      n_fail++;
      $display("FAIL basic_stream: got len %0d, want len %0d, first diff at %0d",
               s.len(), exp_s.len(), first_diff(s, exp_s));
    end
    n_tests++;
    if (first_push() != n0 + 1) begin
      n_fail++;
      $display("FAIL basic_first_push: got cycle %0d, want %0d", first_push(), n0 + 1);
    end
    n_tests++;
    if (last_push() != n0 + NT) begin
      n_fail++;
      $display("FAIL basic_last_push: got cycle %0d, want %0d", last_push(), n0 + NT);
    end
    n_tests++;
    if (flush_at() != n0 + NT + 2) begin
      n_fail++;
      $display("FAIL basic_flush: got cycle %0d (count %0d), want single at %0d",
               flush_at(), flush_cyc_q.size(), n0 + NT + 2);
    end
    n_tests++;
    if (snd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_after: got busy=%b, want 0", snd_busy);
    end
  endtask

  task automatic test_backpressure();
    string exp_s = {"FFFFFFFF 00000000", TERM};
    string s;
    clear_log();
    run_cycle(0, 1, 1, 0, 64'hFFFF_FFFF_0000_0000);
    for (int k = 0; k < 2 * NT + 10; k++)
      run_cycle((k % 2) == 0, 1, 0, 0, 64'h0);
    s = got_str();
    n_tests++;
    if (s != exp_s) begin
      n_fail++;
      $display("FAIL bp_stream: got len %0d, want len %0d, first diff at %0d",
               s.len(), exp_s.len(), first_diff(s, exp_s));
    end
    n_tests++;
    if (full_push_viol != 0) begin
      n_fail++;
      $display("FAIL bp_push_while_full: got %0d pushes with tx_full high, want 0",
               full_push_viol);
    end
    n_tests++;
    if (flush_cyc_q.size() != 1) begin
      n_fail++;
      $display("FAIL bp_flush_count: got %0d, want 1", flush_cyc_q.size());
    end
  endtask

  task automatic test_drain();
    string exp_s = {"A5A55A5A 1234ABCD", TERM};
    string s;
    int e;
    int busy_low_wait;
    clear_log();
    run_cycle(0, 1, 1, 0, 64'hA5A5_5A5A_1234_ABCD);
    busy_low_cnt = 0;
    repeat (NT + 50) run_cycle(0, 0, 0, 0, 64'h0);
    busy_low_wait = busy_low_cnt;
    n_tests++;
    if (flush_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_early_flush: got %0d flushes before tx_empty, want 0",
               flush_cyc_q.size());
    end
    n_tests++;
    if (busy_low_wait != 0) begin
      n_fail++;
      $display("FAIL drain_busy: got busy low in %0d cycles, want 0", busy_low_wait);
    end
    e = cyc;
    repeat (6) run_cycle(0, 1, 0, 0, 64'h0);
    n_tests++;
    if (flush_at() != e + 1) begin
      n_fail++;
      $display("FAIL drain_flush: got cycle %0d (count %0d), want single at %0d",
               flush_at(), flush_cyc_q.size(), e + 1);
    end
    s = got_str();
    n_tests++;
    if (s != exp_s) begin
      n_fail++;
      $display("FAIL drain_stream: got len %0d, want len %0d, first diff at %0d",
               s.len(), exp_s.len(), first_diff(s, exp_s));
    end
  endtask

  task automatic test_abort();
    string exp_part = "11112";
    string exp_new  = {"FEDCBA98 76543210", TERM};
    string s;
    clear_log();
    // Abort coincides with the 5th push: that char is accepted, nothing after
    run_cycle(0, 1, 1, 0, 64'h1111_2222_3333_4444);
    repeat (4) run_cycle(0, 1, 0, 0, 64'h0);
    run_cycle(0, 1, 0, 1, 64'h0);
    run_cycle(0, 1, 0, 0, 64'h0);
    n_tests++;
    if (snd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b after abort, want 0", snd_busy);
    end
    repeat (NT + 5) run_cycle(0, 1, 0, 0, 64'h0);
    s = got_str();
    n_tests++;
    if (s != exp_part || flush_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_partial: got \"%s\" and %0d flushes, want \"%s\" and 0",
               s, flush_cyc_q.size(), exp_part);
    end
    clear_log();
    run_cycle(0, 1, 1, 0, 64'hFEDC_BA98_7654_3210);
    repeat (NT + 6) run_cycle(0, 1, 0, 0, 64'h0);
    s = got_str();
    n_tests++;
    if (s != exp_new || flush_cyc_q.size() != 1) begin
      n_fail++;
      $display("FAIL abort_restart: got len %0d (%0d flushes), want len %0d (1), first diff at %0d",
               s.len(), flush_cyc_q.size(), exp_new.len(), first_diff(s, exp_new));
    end
    // Start and abort together in IDLE: abort wins
    clear_log();
    run_cycle(0, 1, 1, 1, 64'h0123_4567_89AB_CDEF);
    run_cycle(0, 1, 0, 0, 64'h0);
    n_tests++;
    if (snd_busy !== 1'b0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_vs_start: got busy=%b pushes=%0d, want 0 and 0",
               snd_busy, got_q.size());
    end
    // Abort in DRAIN on the same cycle tx_empty rises: no flush
    clear_log();
    run_cycle(0, 0, 1, 0, 64'h0123_4567_89AB_CDEF);
    repeat (NT + 3) run_cycle(0, 0, 0, 0, 64'h0);
    run_cycle(0, 1, 0, 1, 64'h0);
    repeat (5) run_cycle(0, 1, 0, 0, 64'h0);
    n_tests++;
    if (flush_cyc_q.size() != 0 || snd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_drain: got %0d flushes busy=%b, want 0 flushes busy=0",
               flush_cyc_q.size(), snd_busy);
    end
  endtask

  task automatic test_start_busy();
    string exp_s = {"01234567 89ABCDEF", TERM};
    string s;
    int n0;
    clear_log();
    run_cycle(0, 1, 1, 0, 64'h0123_4567_89AB_CDEF);
    n0 = cyc - 1;
    repeat (4) run_cycle(0, 1, 0, 0, 64'h0);
    run_cycle(0, 1, 1, 0, 64'hDEAD_BEEF_CAFE_F00D);
    repeat (NT + 6) run_cycle(0, 1, 0, 0, 64'h0);
    s = got_str();
    n_tests++;
    if (s != exp_s) begin
      n_fail++;
      $display("FAIL busy_start_stream: got len %0d, want len %0d, first diff at %0d",
               s.len(), exp_s.len(), first_diff(s, exp_s));
    end
    n_tests++;
    if (flush_at() != n0 + NT + 2) begin
      n_fail++;
      $display("FAIL busy_start_flush: got cycle %0d (count %0d), want single at %0d",
               flush_at(), flush_cyc_q.size(), n0 + NT + 2);
    end
  endtask

  task automatic test_zero_word();
    string exp_s = {"00000000 00000000", TERM};
    string s;
    int n0;
    clear_log();
    run_cycle(0, 1, 1, 0, 64'h0);
    n0 = cyc - 1;
    repeat (NT + 6) run_cycle(0, 1, 0, 0, 64'h0);
    s = got_str();
    n_tests++;
    if (s != exp_s || got_q.size() != NT) begin
      n_fail++;
      $display("FAIL zero_stream: got len %0d, want len %0d, first diff at %0d",
               s.len(), exp_s.len(), first_diff(s, exp_s));
    end
    n_tests++;
    if (flush_at() != n0 + NT + 2) begin
      n_fail++;
      $display("FAIL zero_flush: got cycle %0d (count %0d), want single at %0d",
               flush_at(), flush_cyc_q.size(), n0 + NT + 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_drain();
    test_abort();
    test_start_busy();
    test_zero_word();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
